mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Line-granularity arbiter that shares the single physical-memory port between the instruction cache and the data cache of the pipelined CPU. It sits between the two cache miss/write-back interfaces and the cacheline adaptor. It serialises requests with data-cache priority and an instruction-starvation guard. It latches each granted transaction so that requester-side changes cannot corrupt an in-flight memory access.

## Interface
Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cacheline width in bits
- STARVE_LIMIT, 3, maximum consecutive D grants while I is waiting (1..15)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line-fill request
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  fill data; valid only while i_resp=1
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line-fill request
- d_write  in  1  D-cache write-back request
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back data
- d_rdata  out  LINE_W  fill data; valid only while d_resp=1
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data; valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE: no pmem request is driven. Grant selection:
  - Only d_* requesting: grant D.
  - Only i_read requesting: grant I.
  - Both requesting: grant D, unless d_streak == STARVE_LIMIT, in which case grant I.
  - On grant, latch the operation, address and wdata into the transaction register and move to I_BUSY or D_BUSY.
- d_read and d_write both asserted: treated as a write. Not a legal cache output; this rule is only defined fallback behaviour.
- I_BUSY / D_BUSY:
  - pmem_read or pmem_write is driven from the latched operation, with pmem_addr and pmem_wdata from the latched values.
  - Requester inputs are ignored.
  - Held until pmem_resp=1. On that cycle, pmem_rdata is captured into the line buffer (for reads) and the FSM moves to RESP.
- RESP:
  - i_resp or d_resp=1 for the granted side only.
  - The matching x_rdata carries the line buffer; x_rdata is 0 for writes.
  - pmem_* requests are 0. Next state is IDLE.
- Requester contract: a cache deasserts its request in the cycle after its resp. The arbiter does not filter stale requests.
- d_streak, a counter of width $clog2(STARVE_LIMIT+1), updates at grant time:
  - On a D grant with i_read=1: increment, saturating at STARVE_LIMIT.
  - On a D grant with i_read=0: clear.
  - On an I grant: clear.
- Outside their resp cycle, i_rdata and d_rdata are 0.

## Timing
- Reset: state=IDLE, d_streak=0, line buffer=0. All outputs are 0: pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- Request seen in IDLE at cycle 0:
  - pmem_read or pmem_write is asserted from cycle 1.
  - If pmem_resp arrives at cycle k≥1, x_resp is asserted at cycle k+1.
  - The FSM is back in IDLE at cycle k+2, so the next grant is possible at k+2.
- Minimum occupancy is 3 cycles per transaction (grant, busy, resp).
- pmem outputs are registered and stable for the entire busy phase. They do not change even if requester inputs toggle.
- A pmem_resp received outside I_BUSY/D_BUSY is ignored.
- Reset asserted mid-transaction: state goes to IDLE on that edge, so pmem requests drop the next cycle. The transaction is abandoned, and no x_resp is issued for it.
- A request arriving during RESP is not granted before IDLE, i.e. one cycle later.

## Test plan
- Single I fill: i_read=1, i_addr=0x0000_1040; memory responds 4 cycles later with rdata=0xA5…A5. Expect:
  - pmem_read=1 with pmem_addr=0x1040 from cycle 1.
  - i_resp=1 for exactly one cycle, carrying that data.
  - d_resp stays 0.
- D write-back: d_write=1, d_addr=0x8000_0020, d_wdata=0x1234…. Expect pmem_write=1 with matching addr and wdata, then d_resp pulse with d_rdata=0. Also change d_addr mid-busy and confirm pmem_addr holds 0x8000_0020.
- Simultaneous requests: i_read and d_read held continuously with STARVE_LIMIT=3; each cache drops its request one cycle after resp, then re-asserts. Expected grant order: D, D, D, I, D, D, D, I.
- Write precedence: d_read=d_write=1. Expect pmem_write=1 and pmem_read=0.
- Reset mid-fill: assert rst during D_BUSY. Expect pmem_read=0 the next cycle, no d_resp, and d_streak=0. A following i_read is granted normally.
- Spurious pmem_resp in IDLE: no x_resp, and the state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// D-cache has priority, with a streak counter guaranteeing the I-cache a turn.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [SW-1:0]     d_streak, streak_nxt;
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LINE_W-1:0] wdata_nxt;
  logic              i_resp_nxt, d_resp_nxt;
  logic [LINE_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              d_req;
  logic              streak_full;

  assign d_req       = d_read | d_write;
  assign streak_full = (d_streak == SW'(STARVE_LIMIT));

  // The pmem output registers double as the transaction register; the
  // rdata output registers double as the line buffer.
  always_comb begin
    state_nxt   = state;
    streak_nxt  = d_streak;
    read_nxt    = pmem_read;
    write_nxt   = pmem_write;
    addr_nxt    = pmem_addr;
    wdata_nxt   = pmem_wdata;
    i_resp_nxt  = 1'b0;
    d_resp_nxt  = 1'b0;
    i_rdata_nxt = '0;
    d_rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (d_req && !(i_read && streak_full)) begin
          state_nxt  = D_BUSY;
          read_nxt   = ~d_write;
          write_nxt  = d_write;
          addr_nxt   = d_addr;
          wdata_nxt  = d_wdata;
          if (i_read) begin
            streak_nxt = streak_full ? d_streak : SW'(d_streak + SW'(1));
          end else begin
            streak_nxt = '0;
          end
        end else if (i_read) begin
          state_nxt  = I_BUSY;
          read_nxt   = 1'b1;
          write_nxt  = 1'b0;
          addr_nxt   = i_addr;
          wdata_nxt  = '0;
          streak_nxt = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_nxt = RESP;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          addr_nxt  = '0;
          wdata_nxt = '0;
          if (state == I_BUSY) begin
            i_resp_nxt  = 1'b1;
            i_rdata_nxt = pmem_rdata;
          end else begin
            d_resp_nxt  = 1'b1;
            d_rdata_nxt = pmem_write ? '0 : pmem_rdata;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      d_streak   <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      d_streak   <= streak_nxt;
      pmem_read  <= read_nxt;
      pmem_write <= write_nxt;
      pmem_addr  <= addr_nxt;
      pmem_wdata <= wdata_nxt;
      i_resp     <= i_resp_nxt;
      d_resp     <= d_resp_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory requests
// and cache responses; a memory model and a response monitor check them.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_resp, d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct { logic is_d; logic [LW-1:0] data; } resp_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; logic [LW-1:0] rdata; } mreq_t;

  resp_t rsp_q[$];
  mreq_t mem_q[$];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned presp_cyc = 0;
  int unsigned last_resp_cyc = 0;
  int          mem_lat = 2;
  int          spur_req = 0;
  int          spur_done = 0;
  bit          b2b = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  mreq_t       cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory model: checks each request against the queue, holds it stable, replies after mem_lat.
  always @(negedge clk) begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (spur_req != spur_done) begin
      spur_done  = spur_req;
      pmem_resp  = 1'b1;
      pmem_rdata = {8{32'hBAD0BAD0}};
    end else if (!mem_busy) begin
      if (pmem_read || pmem_write) begin
        if (mem_q.size() == 0) begin
          fail_now("unexpected_pmem_request");
          cur = '{1'b0, '0, '0, '0};
        end else begin
          cur = mem_q.pop_front();
          check("pmem_write", LW'(pmem_write), LW'(cur.wr));
          check("pmem_read", LW'(pmem_read), LW'(!cur.wr));
          check("pmem_addr", LW'(pmem_addr), LW'(cur.addr));
          check("pmem_wdata", pmem_wdata, cur.wdata);
          if (b2b) check("grant_after_resp", LW'(cyc), LW'(last_resp_cyc + 2));
        end
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
      end
    end else if (!(pmem_read || pmem_write)) begin
      mem_busy = 1'b0;
    end else begin
      check("busy_addr_stable", LW'(pmem_addr), LW'(cur.addr));
      check("busy_wdata_stable", pmem_wdata, cur.wdata);
      mem_cnt--;
    end
    if (mem_busy && mem_cnt == 0) begin
      pmem_resp  = 1'b1;
      pmem_rdata = cur.rdata;
      presp_cyc  = cyc;
      mem_busy   = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every resp pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_resp || d_resp) begin
        last_resp_cyc = cyc;
        if (i_resp && d_resp) fail_now("both_resp");
        if (rsp_q.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          resp_t e;
          e = rsp_q.pop_front();
          check("resp_side", LW'(d_resp), LW'(e.is_d));
          check("resp_rdata", e.is_d ? d_rdata : i_rdata, e.data);
          check("other_rdata", e.is_d ? i_rdata : d_rdata, '0);
          check("resp_latency", LW'(cyc), LW'(presp_cyc + 1));
        end
      end else if (i_rdata != '0 || d_rdata != '0) begin
        fail_now("rdata_outside_resp");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (rsp_q.size() != 0 || mem_q.size() != 0); i++) tick();
    if (rsp_q.size() != 0 || mem_q.size() != 0) begin
      fail_now("drain_timeout");
      rsp_q.delete();
      mem_q.delete();
    end
    tick();
    tick();
  endtask

  // One isolated transaction, checking the cycle-0 / cycle-1 request timing.
  task automatic issue(input bit is_d, input bit rd, input bit wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wdata, input logic [LW-1:0] rdata, input int lat);
    bit wr_eff;
    wr_eff  = is_d && wr;
    mem_lat = lat;
    mem_q.push_back('{wr_eff, addr, is_d ? wdata : '0, rdata});
    rsp_q.push_back('{is_d, wr_eff ? '0 : rdata});
    if (is_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_read = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    check("req_cycle0", LW'({pmem_read, pmem_write}), '0);
    tick();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    d_addr = 32'hDEAD_BEE0; d_wdata = ~wdata; i_addr = 32'hFFFF_FFC0;
    @(negedge clk);
    check("req_cycle1_read", LW'(pmem_read), LW'(!wr_eff));
    check("req_cycle1_write", LW'(pmem_write), LW'(wr_eff));
    wait_drain(60);
  endtask

  function automatic logic [AW-1:0] d_a(input int n);
    return 32'h0000_2000 + AW'(n) * 32'h20;
  endfunction

  function automatic logic [AW-1:0] i_a(input int n);
    return 32'h0000_1000 + AW'(n) * 32'h40;
  endfunction

  initial begin
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_pmem_addr", LW'(pmem_addr), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_resp", LW'(i_resp), '0);
    check("rst_d_resp", LW'(d_resp), '0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    tick();
    rst = 1'b0;
    tick();

    // Single I fill, 4-cycle memory latency
    issue(1'b0, 1'b1, 1'b0, 32'h0000_1040, '0, {32{8'hA5}}, 4);
    // D write-back with requester inputs changing mid-busy
    issue(1'b1, 1'b0, 1'b1, 32'h8000_0020, {8{32'h1234_5678}}, {8{32'h5555_AAAA}}, 3);
    // d_read and d_write together resolve to a write
    issue(1'b1, 1'b1, 1'b1, 32'h0000_3000, {8{32'hCAFE_F00D}}, {8{32'h7777_0000}}, 1);
    // Minimum occupancy: memory answers in the first busy cycle
    issue(1'b0, 1'b1, 1'b0, 32'h0000_5000, '0, {8{32'h0BAD_CAFE}}, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_6020, {8{32'h0101_0101}}, {8{32'hFEED_BEEF}}, 0);

    // Continuous contention: expect D,D,D,I,D,D,D,I
    begin
      int nd = 0;
      int ni = 0;
      int pd = 0;
      int pi = 0;
      bit seen;
      bit was_d;
      string order = "DDDIDDDI";
      for (int g = 0; g < 8; g++) begin
        if (order[g] == "D") begin
          mem_q.push_back('{1'b0, d_a(pd), '0, {8{d_a(pd)}}});
          rsp_q.push_back('{1'b1, {8{d_a(pd)}}});
          pd++;
        end else begin
          mem_q.push_back('{1'b0, i_a(pi), '0, {8{i_a(pi)}}});
          rsp_q.push_back('{1'b0, {8{i_a(pi)}}});
          pi++;
        end
      end
      mem_lat = 2;
      i_read = 1'b1; i_addr = i_a(0);
      d_read = 1'b1; d_addr = d_a(0); d_wdata = '0;
      for (int g = 0; g < 8; g++) begin
        seen  = 1'b0;
        was_d = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
          @(negedge clk);
          if (i_resp || d_resp) begin
            seen  = 1'b1;
            was_d = d_resp;
          end
        end
        if (!seen) begin
          fail_now("contention_timeout");
          break;
        end
        b2b = 1'b1;
        tick();
        if (g == 7) begin
          i_read = 1'b0; d_read = 1'b0;
        end else if (was_d) begin
          nd++; d_addr = d_a(nd);
        end else begin
          ni++; i_addr = i_a(ni);
        end
      end
      i_read = 1'b0; d_read = 1'b0;
      wait_drain(60);
      b2b = 1'b0;
    end

    // Reset during D_BUSY after the streak has been bumped
    mem_lat = 20;
    mem_q.push_back('{1'b0, 32'h0000_4000, '0, '0});
    i_read = 1'b1; i_addr = 32'h0000_7000;
    d_read = 1'b1; d_addr = 32'h0000_4000;
    tick();
    i_read = 1'b0; d_read = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("busy_before_rst", LW'(pmem_read), LW'(1'b1));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("pmem_read_after_rst", LW'(pmem_read), '0);
    check("d_streak_after_rst", LW'(dut.d_streak), '0);
    repeat (4) tick();
    issue(1'b0, 1'b1, 1'b0, 32'h0000_7000, '0, {8{32'h3C3C_3C3C}}, 2);

    // Spurious pmem_resp while idle
    spur_req++;
    tick();
    tick();
    @(negedge clk);
    check("spurious_no_read", LW'({pmem_read, pmem_write}), '0);
    tick();
    issue(1'b1, 1'b1, 1'b0, 32'h0000_9040, '0, {8{32'h9999_1111}}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
